// File: rtl/param_down_counter.sv
// param_down_counter
//
// Loadable modulo down-counter with a registered terminal-count pulse. Software
// loads a start value; the count decrements on every enabled clock while
// running. When an enabled edge sees zero, tc pulses for one cycle and the
// counter either reloads (periodic) or stops in IDLE (one-shot). Wide counts
// are built from SEG_W-bit segments chained by a borrow, so carry logic stays
// short while the block behaves exactly like one W-bit counter.
//
// Ports:
//   clk       rising-edge clock
//   rst_      asynchronous active-low reset
//   en        count enable (ignored in IDLE)
//   load      load strobe, highest priority, any state
//   load_val  start/reload value, clamped to MOD-1
//   periodic  1 = reload at zero, 0 = one-shot; sampled on the zero edge
//   q         current count
//   tc        terminal-count pulse (registered)
//   busy      high while running

module param_down_counter #(
    parameter int unsigned MOD   = 40000,
    parameter int unsigned SEG_W = 16,
    localparam int unsigned W    = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         periodic,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         busy
);

    localparam int unsigned NSEG = (W + SEG_W - 1) / SEG_W;
    localparam logic [W-1:0] MaxVal = W'(MOD - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e         state_q;
    logic [W-1:0]   q_q;
    logic [W-1:0]   reload_q;
    logic           tc_q;

    logic [W-1:0]   q_dec;
    logic [W-1:0]   load_eff;
    logic [NSEG-1:0] seg_zero;
    logic [NSEG-1:0] borrow;
    logic           cnt_zero;

    // Per-segment decrement: a segment steps only when every lower segment is
    // zero, so a zero segment with a borrow rolls to all-ones of its own width.
    // The top segment can never roll because the whole count is nonzero
    // whenever the decremented value is used.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int unsigned Lo = k * SEG_W;
        localparam int unsigned Hi = (Lo + SEG_W > W) ? W - 1 : Lo + SEG_W - 1;
        localparam int unsigned SW = Hi - Lo + 1;

        assign seg_zero[k] = (q_q[Hi:Lo] == '0);
        assign q_dec[Hi:Lo] = borrow[k] ? (q_q[Hi:Lo] - SW'(1)) : q_q[Hi:Lo];
    end

    always_comb begin
        borrow[0] = 1'b1;
        for (int k = 1; k < NSEG; k++) begin
            borrow[k] = borrow[k-1] & seg_zero[k-1];
        end
    end

    assign cnt_zero = &seg_zero;
    assign load_eff = (load_val > MaxVal) ? MaxVal : load_val;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= StIdle;
            q_q      <= '0;
            reload_q <= MaxVal;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (load) begin
                q_q      <= load_eff;
                reload_q <= load_eff;
                state_q  <= StRun;
            end else if (state_q == StRun && en) begin
                if (cnt_zero) begin
                    tc_q <= 1'b1;
                    if (periodic) begin
                        q_q <= reload_q;
                    end else begin
                        state_q <= StIdle;
                    end
                end else begin
                    q_q <= q_dec;
                end
            end
        end
    end

    assign q    = q_q;
    assign tc   = tc_q;
    assign busy = (state_q == StRun);

endmodule

// File: tb/tb_param_down_counter.sv
// Directed bench: instance a (MOD=40000, single segment) and instance b
// (MOD=100000, two cascaded segments) checked against hand-computed values and
// a small behavioural model of a plain 17-bit counter.

module tb_param_down_counter;

    logic clk;
    logic rst_;

    logic        en_a, load_a, periodic_a;
    logic [15:0] load_val_a, q_a;
    logic        tc_a, busy_a;

    logic        en_b, load_b, periodic_b;
    logic [16:0] load_val_b, q_b;
    logic        tc_b, busy_b;

    int checks = 0;
    int errors = 0;

    param_down_counter #(.MOD(40000), .SEG_W(16)) dut_a (
        .clk(clk), .rst_(rst_), .en(en_a), .load(load_a), .load_val(load_val_a),
        .periodic(periodic_a), .q(q_a), .tc(tc_a), .busy(busy_a)
    );

    param_down_counter #(.MOD(100000), .SEG_W(16)) dut_b (
        .clk(clk), .rst_(rst_), .en(en_b), .load(load_b), .load_val(load_val_b),
        .periodic(periodic_b), .q(q_b), .tc(tc_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            if (errors <= 30) $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model for the cascaded instance: one-shot behaviour of a flat counter.
    logic [16:0] ref_q;
    logic        ref_tc, ref_busy;

    // Periodic-with-pause expectations, one entry per edge, en = 1,0,1,0,...
    logic [15:0] per_q  [9] = '{16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd3, 16'd3, 16'd2};
    logic        per_tc [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_ = 1'b0;
        en_a = 1'b0; load_a = 1'b0; periodic_a = 1'b0; load_val_a = '0;
        en_b = 1'b0; load_b = 1'b0; periodic_b = 1'b0; load_val_b = '0;

        // Reset state
        #12;
        chk("rst_q", 32'(q_a), 0);
        chk("rst_tc", 32'(tc_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        rst_ = 1'b1;
        tick();

        // Reset mid-count at q=123
        load_val_a = 16'd125; load_a = 1'b1; en_a = 1'b1;
        tick();
        load_a = 1'b0;
        tick();
        tick();
        chk("mid_q", 32'(q_a), 123);
        chk("mid_busy", 32'(busy_a), 1);
        #2 rst_ = 1'b0;
        #1;
        chk("async_rst_q", 32'(q_a), 0);
        chk("async_rst_tc", 32'(tc_a), 0);
        chk("async_rst_busy", 32'(busy_a), 0);
        rst_ = 1'b1;
        tick(); tick(); tick();
        chk("idle_en_q", 32'(q_a), 0);
        chk("idle_en_busy", 32'(busy_a), 0);
        chk("idle_en_tc", 32'(tc_a), 0);

        // One-shot from 5
        load_val_a = 16'd5; periodic_a = 1'b0; load_a = 1'b1; en_a = 1'b1;
        tick();
        load_a = 1'b0;
        chk("os_load_q", 32'(q_a), 5);
        chk("os_load_busy", 32'(busy_a), 1);
        chk("os_load_tc", 32'(tc_a), 0);
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk("os_q", 32'(q_a), 32'(i));
            chk("os_tc_low", 32'(tc_a), 0);
        end
        tick();
        chk("os_tc", 32'(tc_a), 1);
        chk("os_busy_fall", 32'(busy_a), 0);
        chk("os_q_end", 32'(q_a), 0);
        tick();
        chk("os_tc_once", 32'(tc_a), 0);
        chk("os_q_hold", 32'(q_a), 0);

        // Periodic reload 3 with alternating enable
        load_val_a = 16'd3; periodic_a = 1'b1; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        chk("per_load_q", 32'(q_a), 3);
        for (int i = 0; i < 9; i++) begin
            en_a = (i % 2 == 0);
            tick();
            chk("per_q", 32'(q_a), 32'(per_q[i]));
            chk("per_tc", 32'(tc_a), 32'(per_tc[i]));
        end

        // Clamp
        en_a = 1'b1; load_val_a = 16'd65535; load_a = 1'b1;
        tick();
        chk("clamp_q", 32'(q_a), 39999);

        // Zero load, periodic: tc every enabled edge
        load_val_a = 16'd0; periodic_a = 1'b1;
        tick();
        load_a = 1'b0;
        chk("zero_load_q", 32'(q_a), 0);
        chk("zero_load_tc", 32'(tc_a), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zero_tc", 32'(tc_a), 1);
            chk("zero_q", 32'(q_a), 0);
            chk("zero_busy", 32'(busy_a), 1);
        end

        // Load collides with a zero edge
        periodic_a = 1'b0; load_val_a = 16'd1; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        tick();
        chk("coll_pre_q", 32'(q_a), 0);
        load_val_a = 16'd7; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        chk("coll_tc", 32'(tc_a), 0);
        chk("coll_q", 32'(q_a), 7);
        chk("coll_busy", 32'(busy_a), 1);

        // Cascade: 65536 in a 17-bit counter built from 16+1 bit segments
        en_a = 1'b0;
        load_val_b = 17'd65536; periodic_b = 1'b0; load_b = 1'b1; en_b = 1'b1;
        tick();
        load_b = 1'b0;
        chk("cas_load_q", 32'(q_b), 65536);
        ref_q = 17'd65536; ref_tc = 1'b0; ref_busy = 1'b1;
        for (int n = 1; n <= 65538; n++) begin
            tick();
            ref_tc = 1'b0;
            if (ref_busy) begin
                if (ref_q == 17'd0) begin
                    ref_tc   = 1'b1;
                    ref_busy = 1'b0;
                end else begin
                    ref_q = ref_q - 17'd1;
                end
            end
            chk("cas_model_q", 32'(q_b), 32'(ref_q));
            chk("cas_model_tc", 32'(tc_b), 32'(ref_tc));
            chk("cas_model_busy", 32'(busy_b), 32'(ref_busy));
            if (n == 1) chk("cas_borrow_q", 32'(q_b), 65535);
            if (n == 65536) chk("cas_zero_q", 32'(q_b), 0);
            if (n == 65537) chk("cas_tc", 32'(tc_b), 1);
            if (n == 65538) chk("cas_tc_once", 32'(tc_b), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
